matrix_operand_loader: RTL
==========================

Name: matrix_operand_loader

Overview:
- Upstream feeder for the 4x4 matrix multiplier. Accepts a byte stream of 32 elements over a valid/ready handshake: all 16 elements of A, then all 16 of B, each row-major.
- Assembles each frame in a shadow buffer, then commits it in one cycle onto the flat operand buses that drive the multiplier.
- Pulses res_valid in the cycle the multiplier's registered product for that frame is stable.
- Double-buffered, so the next frame loads while the current one computes.

Parameters:
- ELEM_W, 8, element width in bits. Must match the multiplier input width.
- N, 4, matrix dimension. Fixed at 4 for this design; the parameter is for package consistency only.
- MUL_LATENCY, 1, clock edges from an operand change to a stable product at the multiplier output. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  ELEM_W  stream element
- s_valid  in  1  s_data is valid
- s_ready  out  1  loader can accept an element
- A_flat  out  ELEM_W*N*N  committed A; element (i,j) at bits [(i*4+j)*8 +: 8]
- B_flat  out  ELEM_W*N*N  committed B; same packing as A_flat
- res_valid  out  1  one-cycle pulse: multiplier output now holds the product of the last commit
- busy  out  1  a committed frame is still waiting for its result

Behaviour:
- Interface is fixed as stated: one clock; reset is asynchronous and active-low. Clock port is clk; reset port is rst_n.
- Reset values: A_flat=0, B_flat=0, res_valid=0, busy=0, s_ready=0 during reset. Element counter=0, lat_cnt=0, state=FILL. Shadow buffers need no reset.
- Transfer rule: an element transfers on a rising edge where s_valid && s_ready.
  - Element index 0..15 is written to shadow A[idx/4][idx%4].
  - Element index 16..31 is written to shadow B[(idx-16)/4][(idx-16)%4].
- State FILL:
  - s_ready=1.
  - The counter increments on each transfer.
  - On the transfer of index 31, go to FULL and reset the counter to 0.
- State FULL:
  - s_ready=0.
  - When lat_cnt==0: commit on that edge (A_flat/B_flat <= shadow), load lat_cnt=MUL_LATENCY, return to FILL.
  - With lat_cnt==0 already, FULL lasts exactly 1 cycle.
- Latency counter:
  - While lat_cnt!=0 it decrements each edge.
  - res_valid=1 for exactly the cycle after the edge on which lat_cnt goes 1->0.
  - With MUL_LATENCY=1: commit at edge E0; res_valid is high between E1 and E2, matching the multiplier registering C at E1.
- busy = (lat_cnt!=0).
- Back-to-back frames:
  - The commit of the next frame is legal on the same edge that res_valid is asserted, because lat_cnt is already 0 then.
  - A_flat/B_flat never change while busy=1.
- Simultaneous events: a commit and the first transfer of the next frame cannot coincide, because s_ready=0 in FULL. Handshake throughput is therefore 32 elements per 33 cycles, at minimum.
- s_valid low mid-frame: the counter holds and partial contents are retained indefinitely.
- Reset mid-frame or mid-latency:
  - The partial frame is discarded.
  - A pending res_valid is cancelled.
  - Outputs return to their reset values immediately, because reset is asynchronous.
- Arithmetic: counter width 5 bits; lat_cnt width 4 bits; no wrap beyond index 31.

Optional Feature:
- Macro: MATRIX_LOADER_LAST_CHECK_EN.
- When defined, two extra ports exist:
  - s_last  in  1  asserted by the source with element 31 only.
  - frame_err  out  1  sticky error flag; reset 0; cleared only by rst_n.
- A framing error is either:
  - s_last=1 on a transfer with index<31, or
  - s_last=0 on the transfer with index 31.
- On a framing error: frame_err<=1, counter<=0, state stays FILL, and the partial frame is dropped with no commit.
- When the macro is not defined: neither port exists, and the frame boundary is the element count alone.

Decomposition:
- Shared package matrix_accel_pkg holds:
  - constants ELEM_W=8, N=4, ACC_W=16, ELEMS=N*N;
  - the state enum (FILL, FULL);
  - a function flat_idx(i,j) = (i*N+j)*ELEM_W, reused by the multiplier and its result unloader.
- One natural sub-module: matrix_latency_timer. It holds lat_cnt, the start input, busy and the res_valid pulse, parameterised by MUL_LATENCY.
- The FSM, counter and shadow/commit registers stay in the top.

Test Plan:
- Reset then stream bytes 1..16 (A) and 1..16 (B), s_valid held high:
  - 32 transfers.
  - s_ready low for 1 cycle.
  - A_flat[7:0]=1, A_flat[127:120]=16.
  - res_valid pulses exactly 1 cycle after commit.
  - Multiplier C[0][0]=90.
- A=identity, B=bytes 0..15, with s_valid toggled 1-0-1:
  - The frame assembles correctly despite gaps.
  - C equals B.
- Two frames back-to-back with MUL_LATENCY=3:
  - A_flat/B_flat stable for all 3 busy cycles.
  - Second commit no earlier than the first res_valid cycle.
  - Exactly one res_valid per frame.
- Assert rst_n low after 20 transfers, then release:
  - Outputs are 0 and no res_valid occurs.
  - A fresh 32-element frame commits normally.
- With MATRIX_LOADER_LAST_CHECK_EN defined, s_last=1 on index 10:
  - frame_err=1 and no commit occurs.
  - The following correct frame commits, and frame_err stays 1.
- All elements 255:
  - A_flat and B_flat are all ones.
  - Multiplier C = 4*65025 = 260100, truncated to 16 bits = 63492. This confirms the loader passes operands unaltered.

Source files
------------

// File: rtl/matrix_accel_pkg.sv
// Shared constants, loader state encoding and operand-bus packing helper for the 4x4 matrix path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ELEM_W/N/ACC_W/ELEMS constants, load_state_e (FILL, FULL), flat_idx(i,j).
package matrix_accel_pkg;

   localparam int ELEM_W = 8;
   localparam int N      = 4;
   localparam int ACC_W  = 16;
   localparam int ELEMS  = N * N;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } load_state_e;

   // Bit offset of element (i,j) on a flat row-major operand bus.
   function automatic int flat_idx(input int i, input int j);
      return (i * N + j) * ELEM_W;
   endfunction

endpackage

// File: rtl/matrix_latency_timer.sv
// Tracks the multiplier pipeline after an operand commit and flags when its product is stable.
// Latency: res_valid pulses for one cycle, MUL_LATENCY edges after the start edge.
// Backpressure: none; start is only legal while busy is low.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       operands committed on this edge; loads the countdown
//   busy        countdown non-zero (product not yet stable)
//   res_valid   one-cycle pulse after the countdown reaches zero
module matrix_latency_timer #(
   parameter int MUL_LATENCY = 1   // 1..15, must fit the 4-bit countdown
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic res_valid
);

   localparam logic [3:0] LAT_LOAD = 4'(MUL_LATENCY);

   logic [3:0] lat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt   <= 4'd0;
         res_valid <= 1'b0;
      end else begin
         // The edge that takes the count from 1 to 0 is the one on which the
         // multiplier registers the product, so the pulse follows that edge.
         res_valid <= (lat_cnt == 4'd1);
         if (start) begin
            lat_cnt <= LAT_LOAD;
         end else if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
      end
   end

   assign busy = (lat_cnt != 4'd0);

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects a 32-byte stream (A then B, row-major) into shadow buffers and commits both onto the multiplier operand buses in one cycle.
// Latency: commit 1 edge after element 31 when the multiplier is idle; res_valid MUL_LATENCY edges after commit.
// Backpressure: s_ready low while a full frame waits to commit (at least 1 cycle per frame), so 32 elements per 33 cycles max.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   s_data/s_valid/s_ready  element stream handshake
//   A_flat, B_flat    committed operands, element (i,j) at [(i*4+j)*8 +: 8]
//   res_valid         one-cycle pulse: multiplier output holds the product of the last commit
//   busy              a committed frame is still waiting for its result
//   s_last, frame_err only with MATRIX_LOADER_LAST_CHECK_EN: end-of-frame marker and sticky framing error
module matrix_operand_loader #(
   parameter int ELEM_W      = 8,
   parameter int N           = 4,
   parameter int MUL_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ELEM_W-1:0]     s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
`ifdef MATRIX_LOADER_LAST_CHECK_EN
   input  logic                  s_last,
   output logic                  frame_err,
`endif
   output logic [ELEM_W*N*N-1:0] A_flat,
   output logic [ELEM_W*N*N-1:0] B_flat,
   output logic                  res_valid,
   output logic                  busy
);

   import matrix_accel_pkg::*;

   localparam int         NELEM  = N * N;
   localparam logic [0:0] S_FILL = FILL;
   localparam logic [0:0] S_FULL = FULL;

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [4:0]        cnt;
   logic              xfer;
   logic              last_idx;
   logic              frame_bad;
   logic              frame_done;
   logic              commit;
   logic [ELEM_W-1:0] sh_a [NELEM];
   logic [ELEM_W-1:0] sh_b [NELEM];

   assign xfer     = s_valid && s_ready;
   assign last_idx = (cnt == 5'd31);

`ifdef MATRIX_LOADER_LAST_CHECK_EN
   // s_last must coincide exactly with element 31; any disagreement drops the frame.
   assign frame_bad = xfer && (s_last != last_idx);
`else
   assign frame_bad = 1'b0;
`endif

   assign frame_done = xfer && last_idx && !frame_bad;
   // Operands may only move once the previous product has been taken.
   assign commit     = (state == S_FULL) && !busy;

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:  if (frame_done) state_nxt = S_FULL;
         S_FULL:  if (commit)     state_nxt = S_FILL;
         default: state_nxt = S_FILL;
      endcase
   end

   // s_ready is registered from the next state so it is low throughout reset
   // and drops on the same edge that element 31 is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FILL;
         cnt     <= 5'd0;
         s_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         s_ready <= (state_nxt == S_FILL);
         if (frame_done || frame_bad) begin
            cnt <= 5'd0;
         end else if (xfer) begin
            cnt <= cnt + 5'd1;
         end
      end
   end

   // Shadow buffers carry no reset: a partial frame is dead once cnt is cleared.
   always_ff @(posedge clk) begin
      if (xfer) begin
         if (!cnt[4]) begin
            sh_a[cnt[3:0]] <= s_data;
         end else begin
            sh_b[cnt[3:0]] <= s_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A_flat <= '0;
         B_flat <= '0;
      end else if (commit) begin
         for (int k = 0; k < NELEM; k++) begin
            A_flat[k*ELEM_W +: ELEM_W] <= sh_a[k];
            B_flat[k*ELEM_W +: ELEM_W] <= sh_b[k];
         end
      end
   end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
      end else if (frame_bad) begin
         frame_err <= 1'b1;
      end
   end
`endif

   matrix_latency_timer #(
      .MUL_LATENCY (MUL_LATENCY)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (commit),
      .busy      (busy),
      .res_valid (res_valid)
   );

endmodule
